// File: rtl/smoothing_pkg.sv
// Shared sizing for the row-stream moving-average filter.
package smoothing_pkg;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned TAPS      = 4;
  localparam int unsigned LOG2_TAPS = $clog2(TAPS);
  localparam int unsigned SUM_W     = DATA_W + LOG2_TAPS;
endpackage

// File: rtl/sf_delay_line.sv
// Sample delay line: tap 0 (low bits) is newest, tap TAPS-1 (high bits) oldest.
module sf_delay_line
  import smoothing_pkg::*;
#(
  parameter int unsigned DATA_W = smoothing_pkg::DATA_W,
  parameter int unsigned TAPS   = smoothing_pkg::TAPS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enb,
  input  logic [DATA_W-1:0]        din,
  output logic [TAPS*DATA_W-1:0]   taps
);

  // Shift toward the oldest tap on each enabled edge; reset empties the window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      taps <= '0;
    end else if (enb) begin
      taps <= {taps[(TAPS-1)*DATA_W-1:0], din};
    end
  end

endmodule

// File: rtl/smoothing_filter.sv
// Moving-average smoother for a pixel row stream with round-half-up output.
module smoothing_filter
  import smoothing_pkg::*;
#(
  parameter int unsigned DATA_W = smoothing_pkg::DATA_W,
  parameter int unsigned TAPS   = smoothing_pkg::TAPS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic [DATA_W-1:0] In_Arrary,
  output logic [DATA_W-1:0] SmoothedArray
);

  localparam int unsigned LOG2_TAPS = $clog2(TAPS);
  localparam int unsigned SUM_W     = DATA_W + LOG2_TAPS;

  logic [TAPS*DATA_W-1:0] taps;
  logic [SUM_W-1:0]       sum_c;
  logic [SUM_W-1:0]       rounded_c;
  logic [DATA_W-1:0]      avg_c;

  sf_delay_line #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS)
  ) u_delay_line (
    .clk   (clk),
    .reset (reset),
    .enb   (enb),
    .din   (In_Arrary),
    .taps  (taps)
  );

  // Full-width sum cannot overflow; adding TAPS/2 still fits since max sum is 2^SUM_W - TAPS.
  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < TAPS; i++) begin
      sum_c = sum_c + SUM_W'(taps[i*DATA_W +: DATA_W]);
    end
    rounded_c = sum_c + SUM_W'(TAPS / 2);
    avg_c     = DATA_W'(rounded_c >> LOG2_TAPS);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      SmoothedArray <= '0;
    end else if (enb) begin
      SmoothedArray <= avg_c;
    end
  end

endmodule

// File: tb/tb_smoothing_filter.sv
// Scoreboard bench for smoothing_filter: stimulus pushes expected outputs, a monitor checks each edge.
module tb_smoothing_filter;

  logic       clk;
  logic       reset;
  logic       enb;
  logic [7:0] In_Arrary;
  logic [7:0] SmoothedArray;

  int unsigned n_tests;
  int unsigned n_fail;
  int          sb[$];

  smoothing_filter #(.DATA_W(8), .TAPS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .enb           (enb),
    .In_Arrary     (In_Arrary),
    .SmoothedArray (SmoothedArray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One cycle of stimulus; exp is the output required after the coming rising edge.
  task automatic step(input logic en, input int din, input int exp);
    @(negedge clk);
    enb       = en;
    In_Arrary = 8'(din);
    sb.push_back(exp);
  endtask

  task automatic drain();
    int budget;
    budget = 10;
    @(negedge clk);
    enb = 1'b0;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb.size() != 0) begin
      check("scoreboard_drain", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Async reset pulse: output must clear without an edge and stay clear across one.
  task automatic reset_pulse(input string name);
    @(negedge clk);
    enb   = 1'b0;
    reset = 1'b0;
    #1;
    check({name, "_async_clear"}, int'(SmoothedArray), 0);
    enb       = 1'b1;
    In_Arrary = 8'd77;
    @(posedge clk);
    #1;
    check({name, "_held_in_reset"}, int'(SmoothedArray), 0);
    @(negedge clk);
    enb   = 1'b0;
    reset = 1'b1;
  endtask

  // Monitor: one expected value per rising edge while the scoreboard holds entries.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        check("stream_output", int'(SmoothedArray), sb.pop_front());
      end
    end
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b0;
    enb       = 1'b0;
    In_Arrary = '0;
    #1;
    check("reset_state", int'(SmoothedArray), 0);
    #20;
    @(negedge clk);
    reset = 1'b1;

    // Step of 100: ramp 0,25,50,75,100,100.
    step(1, 100, 0);
    step(1, 100, 25);
    step(1, 100, 50);
    step(1, 100, 75);
    step(1, 100, 100);
    step(1, 100, 100);

    // Full scale from a window of 100s: no wrap, settles at 255.
    step(1, 255, 100);
    step(1, 255, 139);
    step(1, 255, 178);
    step(1, 255, 216);
    step(1, 255, 255);
    step(1, 255, 255);

    // Alternating 0/255 settles at 128 (510/4 rounds up).
    step(1, 0,   255);
    step(1, 255, 191);
    step(1, 0,   191);
    step(1, 255, 128);
    step(1, 0,   128);
    step(1, 255, 128);
    step(1, 0,   128);
    drain();

    reset_pulse("mid_row");

    // Enable gap mid-ramp: output holds 25, then the ramp resumes.
    step(1, 100, 0);
    step(1, 100, 25);
    step(0, 33,  25);
    step(0, 44,  25);
    step(0, 55,  25);
    step(1, 100, 50);
    step(1, 100, 75);
    step(1, 100, 100);
    drain();

    reset_pulse("pre_row");

    // A row of 150s, with 37.5 rounding to 38.
    step(1, 150, 0);
    step(1, 150, 38);
    step(1, 150, 75);
    step(1, 150, 113);
    step(1, 150, 150);
    step(1, 150, 150);
    step(1, 150, 150);
    step(1, 150, 150);
    drain();

    reset_pulse("row_restart");

    // Next row restarts from an empty window.
    step(1, 100, 0);
    step(1, 100, 25);
    step(1, 100, 50);
    step(1, 100, 75);
    step(1, 100, 100);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
